// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-unit result FIFOs for X/Y/M, round-robin grant onto one registered
// register-file write port. Optional feature macro: WB_BYPASS_EN (empty-FIFO result goes straight out).
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_wb_valid,
    input  logic              x_wb_writereg,
    input  logic [ADDR_W-1:0] x_wb_regdest,
    input  logic [DATA_W-1:0] x_wb_wbvalue,
    output logic              x_wb_ready,
    input  logic              y_wb_valid,
    input  logic              y_wb_writereg,
    input  logic [ADDR_W-1:0] y_wb_regdest,
    input  logic [DATA_W-1:0] y_wb_wbvalue,
    output logic              y_wb_ready,
    input  logic              m_wb_valid,
    input  logic              m_wb_writereg,
    input  logic [ADDR_W-1:0] m_wb_regdest,
    input  logic [DATA_W-1:0] m_wb_wbvalue,
    output logic              m_wb_ready,
    output logic              wb_reg_en,
    output logic [ADDR_W-1:0] wb_reg_addr,
    output logic [DATA_W-1:0] wb_reg_data,
    output logic [1:0]        wb_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [2:0]        in_vld;
    logic [2:0]        in_wr;
    logic [EW-1:0]     in_ent [3];
    logic [2:0]        rdy;
    logic [2:0]        nonempty;
    logic [2:0]        acc;
    logic [2:0]        req;
    logic [2:0]        push;
    logic [2:0]        pop;
    logic [EW-1:0]     mem_q [3][DEPTH];
    logic [PW-1:0]     rd_ptr_q [3];
    logic [PW-1:0]     wr_ptr_q [3];
    logic [CW-1:0]     cnt_q [3];
    logic [CW-1:0]     cnt_d [3];
    logic [1:0]        rr_q;
    logic [1:0]        gnt_id;
    logic [1:0]        cand;
    logic              gnt_vld;
    logic              byp;
    logic [EW-1:0]     gnt_ent;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        pend_sum;

    assign in_vld    = {m_wb_valid, y_wb_valid, x_wb_valid};
    assign in_wr     = {m_wb_writereg, y_wb_writereg, x_wb_writereg};
    assign in_ent[0] = {x_wb_regdest, x_wb_wbvalue};
    assign in_ent[1] = {y_wb_regdest, y_wb_wbvalue};
    assign in_ent[2] = {m_wb_regdest, m_wb_wbvalue};

    // Ready comes from the registered count only; filtered results are accepted but dropped.
    always_comb begin
        nonempty = '0;
        rdy      = '0;
        acc      = '0;
        for (int u = 0; u < 3; u++) begin
            nonempty[u] = (cnt_q[u] != '0);
            rdy[u]      = (cnt_q[u] < CW'(DEPTH));
            acc[u]      = in_vld[u] & rdy[u] & in_wr[u] & (in_ent[u][EW-1 -: ADDR_W] != '0);
        end
    end

    assign x_wb_ready = rdy[0];
    assign y_wb_ready = rdy[1];
    assign m_wb_ready = rdy[2];

`ifdef WB_BYPASS_EN
    assign req = nonempty | acc;
`else
    assign req = nonempty;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 2'd0;
        cand    = rr_q;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp = gnt_vld & ~nonempty[gnt_id];
`else
    assign byp = 1'b0;
`endif

    assign gnt_ent = byp ? in_ent[gnt_id] : mem_q[gnt_id][rd_ptr_q[gnt_id]];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int u = 0; u < 3; u++) begin
            push[u]  = acc[u] & ~(byp & (gnt_id == 2'(u)));
            pop[u]   = gnt_vld & ~byp & (gnt_id == 2'(u));
            cnt_d[u] = cnt_q[u];
            if (push[u] && !pop[u])
                cnt_d[u] = cnt_q[u] + CW'(1);
            else if (pop[u] && !push[u])
                cnt_d[u] = cnt_q[u] - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int u = 0; u < 3; u++) begin
            if (push[u])
                mem_q[u][wr_ptr_q[u]] <= in_ent[u];
        end
    end

    // rr_q holds the last granted unit; starting at M gives X first priority after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int u = 0; u < 3; u++) begin
                cnt_q[u]    <= '0;
                rd_ptr_q[u] <= '0;
                wr_ptr_q[u] <= '0;
            end
            rr_q   <= 2'd2;
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            for (int u = 0; u < 3; u++) begin
                cnt_q[u] <= cnt_d[u];
                if (push[u])
                    wr_ptr_q[u] <= wr_ptr_q[u] + PW'(1);
                if (pop[u])
                    rd_ptr_q[u] <= rd_ptr_q[u] + PW'(1);
            end
            en_q <= gnt_vld;
            if (gnt_vld) begin
                rr_q   <= gnt_id;
                addr_q <= gnt_ent[EW-1 -: ADDR_W];
                data_q <= gnt_ent[DATA_W-1:0];
            end
        end
    end

    assign pend_sum    = 3'(nonempty[0]) + 3'(nonempty[1]) + 3'(nonempty[2]) + 3'(en_q);
    assign wb_pending  = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
    assign wb_reg_en   = en_q;
    assign wb_reg_addr = addr_q;
    assign wb_reg_data = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              vld [3];
    logic              wr  [3];
    logic [ADDR_W-1:0] rd  [3];
    logic [DATA_W-1:0] dat [3];
    logic              x_rdy, y_rdy, m_rdy;
    logic              wb_reg_en;
    logic [ADDR_W-1:0] wb_reg_addr;
    logic [DATA_W-1:0] wb_reg_data;
    logic [1:0]        wb_pending;

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .x_wb_valid(vld[0]), .x_wb_writereg(wr[0]), .x_wb_regdest(rd[0]), .x_wb_wbvalue(dat[0]), .x_wb_ready(x_rdy),
        .y_wb_valid(vld[1]), .y_wb_writereg(wr[1]), .y_wb_regdest(rd[1]), .y_wb_wbvalue(dat[1]), .y_wb_ready(y_rdy),
        .m_wb_valid(vld[2]), .m_wb_writereg(wr[2]), .m_wb_regdest(rd[2]), .m_wb_wbvalue(dat[2]), .m_wb_ready(m_rdy),
        .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .wb_pending(wb_pending)
    );

    always #5 clock = ~clock;

    // Reference model: one queue per unit, last granted unit, expected output register.
    logic [ADDR_W+DATA_W-1:0] mq [3][$];
    int                m_last;
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    int checks, errors;
    int edge_n, pulses, first_en;
    int obs_edge [$];
    logic [ADDR_W-1:0] obs_addr [$];
    logic [DATA_W-1:0] obs_data [$];
    bit sat;
    int since [3];
    int seq [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int u);
        return (u == 0) ? x_rdy : (u == 1) ? y_rdy : m_rdy;
    endfunction

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; rd[i] = '0; dat[i] = '0;
        end
    endtask

    task automatic drive(input int u, input logic w, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        vld[u] = 1'b1; wr[u] = w; rd[u] = r; dat[u] = d;
    endtask

    task automatic clear_obs();
        pulses = 0; first_en = -1;
        obs_edge.delete(); obs_addr.delete(); obs_data.delete();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        edge_n++;
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_last = 2; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
        chk("rst_en", 64'(wb_reg_en), 64'(0));
        chk("rst_addr", 64'(wb_reg_addr), 64'(0));
        chk("rst_data", 64'(wb_reg_data), 64'(0));
        chk("rst_ready", 64'({m_rdy, y_rdy, x_rdy}), 64'(3'b111));
        chk("rst_pending", 64'(wb_pending), 64'(0));
    endtask

    task automatic tick();
        logic [2:0] acc;
        logic [ADDR_W+DATA_W-1:0] ent;
        int g, u, ne;
        acc = '0;
        ent = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ready_%0d", i), 64'(rdy_of(i)), 64'(mq[i].size() < DEPTH));
            acc[i] = vld[i] && (mq[i].size() < DEPTH) && wr[i] && (rd[i] != 0);
        end
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            u = (m_last + k) % 3;
            if (g < 0 && (mq[u].size() > 0 || (BYP && acc[u]))) g = u;
        end
        exp_en = 1'b0;
        if (g >= 0) begin
            if (mq[g].size() > 0) ent = mq[g].pop_front();
            else begin
                ent = {rd[g], dat[g]};
                acc[g] = 1'b0;
            end
            exp_en   = 1'b1;
            exp_addr = ent[DATA_W +: ADDR_W];
            exp_data = ent[DATA_W-1:0];
            m_last   = g;
        end
        for (int i = 0; i < 3; i++)
            if (acc[i]) mq[i].push_back({rd[i], dat[i]});

        @(posedge clock); #1;
        edge_n++;
        chk("wb_en", 64'(wb_reg_en), 64'(exp_en));
        chk("wb_addr", 64'(wb_reg_addr), 64'(exp_addr));
        chk("wb_data", 64'(wb_reg_data), 64'(exp_data));
        ne = int'(exp_en);
        for (int i = 0; i < 3; i++) ne += int'(mq[i].size() > 0);
        chk("pending", 64'(wb_pending), 64'((ne > 3) ? 3 : ne));

        if (wb_reg_en === 1'b1) begin
            pulses++;
            if (first_en < 0) first_en = edge_n;
            obs_edge.push_back(edge_n);
            obs_addr.push_back(wb_reg_addr);
            obs_data.push_back(wb_reg_data);
            if (sat) begin
                u = int'(wb_reg_data[31:30]);
                if (u < 3) begin
                    chk("starve", 64'(since[u] <= 2), 64'(1));
                    for (int i = 0; i < 3; i++) since[i] = (i == u) ? 0 : since[i] + 1;
                end
            end
        end
    endtask

    initial begin
        int n, i, guard;
        logic acc_now;
        checks = 0; errors = 0; edge_n = 0; sat = 0;
        for (int k = 0; k < 3; k++) begin since[k] = 0; seq[k] = 0; end
        idle();
        clear_obs();
        repeat (2) @(posedge clock);
        do_reset();

        // Single X result.
        clear_obs();
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        n = edge_n;
        idle();
        repeat (4) tick();
        chk("single_latency", 64'(first_en - n), 64'(BYP ? 0 : 1));
        chk("single_pulses", 64'(pulses), 64'(1));
        chk("single_addr", 64'(obs_addr[0]), 64'(5));
        chk("single_data", 64'(obs_data[0]), 64'(32'hDEADBEEF));

        // Simultaneous bursts: X,Y,M order each time.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            clear_obs();
            for (int k = 0; k < 3; k++) drive(k, 1'b1, 5'(3*b + k + 1), 32'hA000 + 32'(3*b + k));
            tick();
            idle();
            repeat (4) tick();
            chk("burst_count", 64'(obs_addr.size()), 64'(3));
            for (int k = 0; k < 3; k++) chk("burst_order", 64'(obs_addr[k]), 64'(3*b + k + 1));
            chk("burst_consecutive", 64'(obs_edge[2] - obs_edge[0]), 64'(2));
        end

        // M streams six results alone.
        clear_obs();
        i = 0; guard = 0;
        while (i < 6 && guard < 40) begin
            drive(2, 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            acc_now = m_rdy;
            tick();
            if (acc_now) i++;
            guard++;
        end
        chk("m_stream_accepts", 64'(i), 64'(6));
        idle();
        repeat (5) tick();
        chk("m_stream_count", 64'(obs_data.size()), 64'(6));
        for (int k = 0; k < 6; k++) chk("m_stream_order", 64'(obs_data[k]), 64'(32'h100 + 32'(k)));

        // Filtered transfers.
        clear_obs();
        drive(0, 1'b0, 5'd7, 32'h77);
        tick();
        idle();
        drive(1, 1'b1, 5'd0, 32'h88);
        tick();
        idle();
        repeat (4) tick();
        chk("filtered_pulses", 64'(pulses), 64'(0));

        // Fill every FIFO, then reset: nothing buffered may come out.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) drive(k, 1'b1, 5'(20 + k), 32'hF000 + 32'(c*4 + k));
            tick();
        end
        chk("fill_pending", 64'(wb_pending), 64'(3));
        do_reset();
        clear_obs();
        repeat (6) tick();
        chk("post_reset_pulses", 64'(pulses), 64'(0));

        // All units saturated for 30 cycles.
        do_reset();
        clear_obs();
        sat = 1;
        for (int c = 0; c < 30; c++) begin
            for (int k = 0; k < 3; k++) begin
                drive(k, 1'b1, 5'($urandom_range(1, 31)), {2'(k), 14'($urandom), 16'(seq[k])});
                seq[k]++;
            end
            tick();
        end
        sat = 0;
        idle();
        repeat (8) tick();
        chk("sat_drained", 64'(wb_pending), 64'(0));

        // Random traffic including filtered and idle slots.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) begin
                vld[k] = ($urandom_range(0, 3) != 0);
                wr[k]  = ($urandom_range(0, 7) != 0);
                rd[k]  = 5'($urandom_range(0, 31));
                dat[k] = $urandom;
            end
            if (c == 150) do_reset();
            else tick();
        end
        idle();
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
